// File: rtl/mod_updown_counter_pkg.sv
// Shared definitions for mod_updown_counter: direction encoding and the
// wrapped next-count function used by the counter datapath.
package mod_updown_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Count values are carried at 32 bits; the modulus needs one extra bit
  // so that MODULUS = 2^32 is representable.
  localparam int unsigned CNT_W = 32;
  localparam int unsigned MOD_W = 33;

  // Next count after one step in direction dir, wrapping modulo 'modulus'.
  function automatic logic [CNT_W-1:0] next_count(
    input logic [CNT_W-1:0] cur,
    input logic             dir,
    input logic [MOD_W-1:0] modulus
  );
    logic [MOD_W-1:0] last;
    last = modulus - MOD_W'(1);
    if (dir == DIR_UP) begin
      return (MOD_W'(cur) == last) ? '0 : cur + CNT_W'(1);
    end else begin
      return (cur == '0) ? CNT_W'(last) : cur - CNT_W'(1);
    end
  endfunction

  // True when a step from 'cur' in direction dir crosses the wrap point.
  function automatic logic is_wrap_step(
    input logic [CNT_W-1:0] cur,
    input logic             dir,
    input logic [MOD_W-1:0] modulus
  );
    if (dir == DIR_UP) begin
      return MOD_W'(cur) == (modulus - MOD_W'(1));
    end else begin
      return cur == '0;
    end
  endfunction

endpackage

// File: rtl/mod_updown_counter_bin_to_gray.sv
// Combinational binary-to-Gray converter.
module bin_to_gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  // Gray code: each bit is the XOR of adjacent binary bits.
  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with load, clear, terminal-count, wrap pulse
// and sticky out-of-range load flag.
// Optional: define MOD_UPDOWN_COUNTER_GRAY_EN to add a registered Gray-coded
// copy of the count on q_gray.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
  output logic [WIDTH-1:0] q_gray,
`endif
  output logic             load_err
);

  localparam logic [MOD_W-1:0] MOD_EXT = MOD_W'(MODULUS);
  localparam logic [WIDTH-1:0] Q_LAST  = WIDTH'(MODULUS - 64'd1);

  // Reject parameter combinations outside the legal range at elaboration.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 2..32");
  end
  if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS must be in 2..2^WIDTH");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  // Next-state: clear beats load beats enabled step; otherwise hold.
  always_comb begin
    q_d        = q_q;
    wrap_d     = 1'b0;
    load_err_d = load_err_q;
    if (clear) begin
      q_d        = '0;
      load_err_d = 1'b0;
    end else if (load) begin
      if (64'(load_val) < MODULUS) begin
        q_d = load_val;
      end else begin
        q_d        = Q_LAST;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      q_d    = WIDTH'(next_count(CNT_W'(q_q), up_dn, MOD_EXT));
      wrap_d = is_wrap_step(CNT_W'(q_q), up_dn, MOD_EXT);
    end
  end

  // Counter state and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q        <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
  logic [WIDTH-1:0] gray_d;
  logic [WIDTH-1:0] q_gray_q;

  bin_to_gray #(.WIDTH(WIDTH)) u_bin_to_gray (
    .bin_i  (q_d),
    .gray_o (gray_d)
  );

  // Gray copy registered from the next count so it tracks q on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_gray_q <= '0;
    end else begin
      q_gray_q <= gray_d;
    end
  end

  assign q_gray = q_gray_q;
`endif

  assign q        = q_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

  // Terminal count: next enabled step in the current direction will wrap.
  assign tc = en & (((up_dn == DIR_UP) && (q_q == Q_LAST)) ||
                    ((up_dn == DIR_DN) && (q_q == '0)));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter (WIDTH=4, MODULUS=10):
// directed sequences with literal expectations plus randomized traffic
// checked every cycle against a modular-arithmetic reference model.
module tb_mod_updown_counter;

  localparam int unsigned W   = 4;
  localparam int          MOD = 10;

  logic         clk;
  logic         reset;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic         clear;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;
  logic         load_err;
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
  logic [W-1:0] q_gray;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  int m_q   = 0;
  int m_wrap = 0;
  int m_err = 0;

  mod_updown_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .clear    (clear),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    .q_gray   (q_gray),
`endif
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: count modulo MOD with plain arithmetic.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q = 0; m_wrap = 0; m_err = 0;
    end else begin
      m_wrap = 0;
      if (clear) begin
        m_q = 0; m_err = 0;
      end else if (load) begin
        if (int'(load_val) < MOD) m_q = int'(load_val);
        else begin m_q = MOD - 1; m_err = 1; end
      end else if (en) begin
        if (up_dn) begin
          m_wrap = (m_q + 1 == MOD) ? 1 : 0;
          m_q = (m_q + 1) % MOD;
        end else begin
          m_wrap = (m_q == 0) ? 1 : 0;
          m_q = (m_q + MOD - 1) % MOD;
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    int exp_tc;
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    int gray_tab [10] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13};
`endif
    exp_tc = (en && ((up_dn && m_q == MOD - 1) || (!up_dn && m_q == 0))) ? 1 : 0;
    chk("q", q, m_q);
    chk("wrap", wrap, m_wrap);
    chk("load_err", load_err, m_err);
    chk("tc", tc, exp_tc);
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    chk("q_gray", q_gray, gray_tab[m_q]);
`endif
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0;
    load_val = '0; clear = 1'b0;
    #100;
    chk("reset_q", q, 0);
    chk("reset_wrap", wrap, 0);
    chk("reset_err", load_err, 0);
    edge1();

    // Up count 12 edges from 0
    reset = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      edge1();
      if (i == 8) begin chk("up_q9", q, 9); chk("up_tc9", tc, 1); end
      if (i == 9) begin chk("up_wrap_q", q, 0); chk("up_wrap", wrap, 1); end
      if (i == 10) begin chk("up_q1", q, 1); chk("up_wrap_gone", wrap, 0); end
    end
    chk("up_end_q", q, 2);

    // Clear, then count down three edges
    en = 1'b0; clear = 1'b1;
    edge1();
    clear = 1'b0; en = 1'b1; up_dn = 1'b0;
    #1;
    chk("dn_tc0", tc, 1);
    edge1(); chk("dn_q9", q, 9); chk("dn_wrap", wrap, 1);
    edge1(); chk("dn_q8", q, 8); chk("dn_wrap_gone", wrap, 0);
    edge1(); chk("dn_q7", q, 7);

    // Load priority and out-of-range load
    load = 1'b1; load_val = 4'd5; en = 1'b1;
    edge1(); chk("ld5_q", q, 5); chk("ld5_err", load_err, 0);
    load_val = 4'd12;
    edge1(); chk("ld12_q", q, 9); chk("ld12_err", load_err, 1);
    load = 1'b0; clear = 1'b1;
    edge1(); chk("clr_q", q, 0); chk("clr_err", load_err, 0);

    // Asynchronous reset mid-period at q=6
    clear = 1'b0; load = 1'b1; load_val = 4'd6;
    edge1(); chk("ld6_q", q, 6);
    load = 1'b0; en = 1'b0;
    #2 reset = 1'b1;
    #1 chk("async_rst_q", q, 0);
    #1 reset = 1'b0; en = 1'b1; up_dn = 1'b1;
    edge1(); chk("post_rst_q", q, 1);

    // Randomized traffic, checked by the per-cycle compare process
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = $urandom_range(0, 1) == 1;
      load     = ($urandom_range(0, 9) == 0);
      load_val = W'($urandom_range(0, 15));
      clear    = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
      edge1();
    end

    en = 1'b0; load = 1'b0; clear = 1'b0;
    edge1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter MODULUS, default 16: count sequence length; legal range 2..2^WIDTH.
REQ-003 The port list SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  count enable; one step per clk while high.
REQ-007 up_dn  input  1  direction: 1 = count up, 0 = count down.
REQ-008 load  input  1  synchronous load request.
REQ-009 load_val  input  WIDTH  value captured on load.
REQ-010 clear  input  1  synchronous clear of q and sticky flags.
REQ-011 q  output  WIDTH  current count, registered.
REQ-012 tc  output  1  terminal count, combinational from registered state.
REQ-013 wrap  output  1  registered one-cycle pulse, high after a wrap step.
REQ-014 load_err  output  1  sticky flag set by an out-of-range load.

Function
REQ-015 Per-edge priority SHALL be clear > load > en; an edge with none of these holds q.
REQ-016 Up step SHALL set q to q+1; from MODULUS-1 it SHALL set q to 0 (wrap).
REQ-017 Down step SHALL set q to q-1; from 0 it SHALL set q to MODULUS-1 (wrap).
REQ-018 q SHALL never hold a value >= MODULUS.
REQ-019 tc SHALL be high while en=1 and either (up_dn=1 and q=MODULUS-1) or (up_dn=0 and q=0).
REQ-020 wrap SHALL be high for exactly the one cycle following the clk edge that performed a wrap step; otherwise low.
REQ-021 A load with load_val < MODULUS SHALL set q to load_val, leave load_err unchanged and force wrap low.
REQ-022 A load with load_val >= MODULUS SHALL set q to MODULUS-1 and set load_err to 1.
REQ-023 When load and en are high together, the load SHALL win and no step SHALL occur.
REQ-024 clear SHALL set q to 0 and both load_err and wrap to 0, regardless of load or en.
REQ-025 A change of up_dn SHALL take effect on the next enabled edge, with no lost or extra step.
REQ-026 Latency: q SHALL reflect a step, load or clear one clk edge after the request is sampled.
REQ-027 When MODULUS = 2^WIDTH, wrap behaviour SHALL equal natural binary overflow and underflow.

Reset
REQ-028 Asserting reset SHALL immediately force q=0, wrap=0 and load_err=0, independent of clk.
REQ-029 Reset asserted mid-count SHALL abandon the count; after release, counting SHALL resume from 0 on the first enabled edge.
REQ-030 While reset is high, all inputs SHALL be ignored.

Configuration
REQ-031 With macro MOD_UPDOWN_COUNTER_GRAY_EN defined, the block SHALL add output q_gray [WIDTH], registered, equal to q XOR (q >> 1) and updated on the same edge as q; it SHALL reset to 0.
REQ-032 Without MOD_UPDOWN_COUNTER_GRAY_EN, q_gray and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 The shared package SHALL hold the direction constants DIR_UP=1 and DIR_DN=0, plus the function computing the next wrapped count.
REQ-034 The block SHALL use one sub-module, bin_to_gray (combinational, parameter WIDTH), instantiated only when MOD_UPDOWN_COUNTER_GRAY_EN is defined.
REQ-035 Elaboration SHALL fail when MODULUS < 2 or MODULUS > 2^WIDTH.

Verification (WIDTH=4, MODULUS=10)
REQ-036 Reset high for 100 ns, then en=1, up_dn=1 for 12 edges -> q = 0,1,..,9,0,1; tc high at q=9; wrap high for the one cycle after q becomes 0.
REQ-037 From q=0: en=1, up_dn=0 for 3 edges -> q = 9,8,7; tc high at q=0; wrap pulse after q becomes 9.
REQ-038 load=1 with load_val=5 and en=1 on the same edge -> q=5 and load_err=0; then load_val=12 -> q=9 and load_err=1; then clear -> q=0 and load_err=0.
REQ-039 Reset asserted asynchronously at q=6, mid-period -> q=0 before the next clk edge; after release, the first enabled edge gives q=1.
REQ-040 MOD_UPDOWN_COUNTER_GRAY_EN defined, up count 0..9 -> q_gray = 0,1,3,2,6,7,5,4,12,13; exactly one bit changes per step except the wrap from 9 to 0.
